// File: rtl/uart_byte_receiver_pkg.sv
// Shared definitions for the UART byte receiver: FSM states, oversample
// ratio and the clock-divider computation.
package uart_byte_receiver_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    // Clocks per oversample tick: round(clk_freq / (baud * OVERSAMPLE)), never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        int unsigned den;
        int unsigned q;
        den = baud * OVERSAMPLE;
        q   = (clk_freq + den / 2) / den;
        return (q == 32'd0) ? 32'd1 : q;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: one-clk tick every DIV clocks, restartable.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   clr   - restart the divider at 0 (no tick in the following cycle)
//   tick  - registered one-clk tick pulse
module uart_rx_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Divider next state
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_byte_receiver.sv
// UART 8N1 byte receiver with 16x oversampling and 3-sample majority vote.
// Ports:
//   clk            - clock, all logic on rising edge
//   rst_n          - synchronous active-low reset
//   RxD            - asynchronous serial input, idle high, LSB first
//   RxD_data       - last correctly framed byte
//   RxD_data_ready - one-clk pulse when RxD_data is updated
//   RxD_data_error - one-clk pulse on framing error (stop bit low)
module uart_byte_receiver
    import uart_byte_receiver_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_data_error
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);

    // Tick positions inside a 16-tick bit period
    localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_V2   = 4'(OVERSAMPLE / 2);
    localparam logic [3:0] TICK_V3   = 4'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    rx_state_e  state_q, state_d;
    logic       rxd_meta_q, rxd_meta_d;
    logic       rxd_sync_q, rxd_sync_d;
    logic       rxd_prev_q, rxd_prev_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] vote_q, vote_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       ready_q, ready_d;
    logic       error_q, error_d;

    logic       tick;
    logic       tick_clr_c;
    logic       start_edge_c;
    logic       maj_c;

    uart_rx_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr_c),
        .tick  (tick)
    );

    // Synchronizer and edge-history inputs
    always_comb begin
        rxd_meta_d = RxD;
        rxd_sync_d = rxd_meta_q;
        rxd_prev_d = rxd_sync_q;
    end

    assign start_edge_c = rxd_prev_q & ~rxd_sync_q;

    // Majority of the two stored samples and the current one (third vote tick)
    assign maj_c = (vote_q[0] & vote_q[1]) |
                   (vote_q[0] & rxd_sync_q) |
                   (vote_q[1] & rxd_sync_q);

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        vote_d     = vote_q;
        shift_d    = shift_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        error_d    = 1'b0;
        tick_clr_c = 1'b0;

        // Tick counting and vote capture while inside a frame
        if (state_q != IDLE && state_q != WAIT_IDLE && tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (tick_cnt_q == TICK_MID) vote_d[0] = rxd_sync_q;
            if (tick_cnt_q == TICK_V2)  vote_d[1] = rxd_sync_q;
        end

        unique case (state_q)
            IDLE: begin
                if (start_edge_c) begin
                    state_d    = START;
                    tick_clr_c = 1'b1;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_MID && rxd_sync_q) begin
                        state_d = IDLE;
                    end else if (tick_cnt_q == TICK_LAST) begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_V3) begin
                        shift_d = {maj_c, shift_q[7:1]};
                    end
                    if (tick_cnt_q == TICK_LAST) begin
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
            end
            STOP: begin
                if (tick && tick_cnt_q == TICK_V3) begin
                    if (maj_c) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                        // A start edge coinciding with the decision is not lost
                        if (start_edge_c) begin
                            state_d    = START;
                            tick_clr_c = 1'b1;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Break or stuck-low line: hold here so only one error is flagged
                if (rxd_sync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            vote_q     <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rxd_meta_q <= rxd_meta_d;
            rxd_sync_q <= rxd_sync_d;
            rxd_prev_q <= rxd_prev_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            vote_q     <= vote_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    assign RxD_data       = data_q;
    assign RxD_data_ready = ready_q;
    assign RxD_data_error = error_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at 32 clk per bit.
module tb_uart_byte_receiver;

    localparam int unsigned CLK_FREQ = 3_200_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int          BIT_CLKS = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_data_error;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state, written only by the monitor processes
    int         cyc = 0;
    int         ready_total = 0;
    int         err_total = 0;
    int         both_total = 0;
    int         ready_cyc = 0;
    logic [7:0] ready_log [0:63];

    uart_byte_receiver #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RxD            (RxD),
        .RxD_data       (RxD_data),
        .RxD_data_ready (RxD_data_ready),
        .RxD_data_error (RxD_data_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (RxD_data_ready) begin
            if (ready_total < 64) ready_log[ready_total] = RxD_data;
            ready_total = ready_total + 1;
            ready_cyc   = cyc;
        end
        if (RxD_data_error) err_total = err_total + 1;
        if (RxD_data_ready && RxD_data_error) both_total = both_total + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive the line to v for n clocks; always ends 1 time unit after a rising edge
    task automatic line(input logic v, input int n);
        RxD = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bc);
        line(1'b0, bc);
        for (int i = 0; i < 8; i++) line(b[i], bc);
        line(stop_bit, bc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r0;
        int e0;
        int t0;
        int lat;

        rst_n = 1'b0;
        RxD   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("rst_data",  32'(RxD_data), 32'h00);
        check_val("rst_ready", 32'(RxD_data_ready), 32'd0);
        check_val("rst_error", 32'(RxD_data_error), 32'd0);
        rst_n = 1'b1;
        line(1'b1, 20);

        // Clean frame 0xA5 with latency measurement
        r0 = ready_total; e0 = err_total; t0 = cyc;
        send_frame(8'hA5, 1'b1, BIT_CLKS);
        line(1'b1, 64);
        lat = ready_cyc - t0;
        check_val("a5_ready_cnt", 32'(ready_total - r0), 32'd1);
        check_val("a5_log",       32'(ready_log[r0]), 32'hA5);
        check_val("a5_data",      32'(RxD_data), 32'hA5);
        check_val("a5_err_cnt",   32'(err_total - e0), 32'd0);
        check_val("a5_latency",   ((lat >= 300) && (lat <= 320)) ? 32'd1 : 32'd0, 32'd1);

        // Framing error followed by a long break
        r0 = ready_total; e0 = err_total;
        send_frame(8'h3C, 1'b0, BIT_CLKS);
        line(1'b0, 20 * BIT_CLKS);
        line(1'b1, 64);
        check_val("brk_err_cnt",   32'(err_total - e0), 32'd1);
        check_val("brk_ready_cnt", 32'(ready_total - r0), 32'd0);
        check_val("brk_data_hold", 32'(RxD_data), 32'hA5);
        r0 = ready_total; e0 = err_total;
        send_frame(8'h81, 1'b1, BIT_CLKS);
        line(1'b1, 64);
        check_val("x81_ready_cnt", 32'(ready_total - r0), 32'd1);
        check_val("x81_data",      32'(RxD_data), 32'h81);
        check_val("x81_err_cnt",   32'(err_total - e0), 32'd0);

        // Short low glitch on an idle line
        r0 = ready_total; e0 = err_total;
        line(1'b0, 6);
        line(1'b1, 64);
        check_val("glitch_ready_cnt", 32'(ready_total - r0), 32'd0);
        check_val("glitch_err_cnt",   32'(err_total - e0), 32'd0);
        send_frame(8'h42, 1'b1, BIT_CLKS);
        line(1'b1, 64);
        check_val("x42_ready_cnt", 32'(ready_total - r0), 32'd1);
        check_val("x42_data",      32'(RxD_data), 32'h42);

        // Back-to-back frames, no idle gap
        r0 = ready_total; e0 = err_total;
        send_frame(8'h00, 1'b1, BIT_CLKS);
        send_frame(8'hFF, 1'b1, BIT_CLKS);
        send_frame(8'h55, 1'b1, BIT_CLKS);
        line(1'b1, 64);
        check_val("b2b_ready_cnt", 32'(ready_total - r0), 32'd3);
        check_val("b2b_log0",      32'(ready_log[r0]), 32'h00);
        check_val("b2b_log1",      32'(ready_log[r0 + 1]), 32'hFF);
        check_val("b2b_log2",      32'(ready_log[r0 + 2]), 32'h55);
        check_val("b2b_err_cnt",   32'(err_total - e0), 32'd0);

        // Reset pulse during data bit 3 of frame 0xF8
        r0 = ready_total; e0 = err_total;
        fork
            send_frame(8'hF8, 1'b1, BIT_CLKS);
            begin
                repeat (BIT_CLKS * 4 + 10) @(posedge clk);
                #2;
                rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #2;
                check_val("mid_rst_data",  32'(RxD_data), 32'h00);
                check_val("mid_rst_ready", 32'(RxD_data_ready), 32'd0);
                check_val("mid_rst_error", 32'(RxD_data_error), 32'd0);
                rst_n = 1'b1;
            end
        join
        line(1'b1, 64);
        check_val("mid_rst_ready_cnt", 32'(ready_total - r0), 32'd0);
        check_val("mid_rst_err_cnt",   32'(err_total - e0), 32'd0);
        send_frame(8'h5A, 1'b1, BIT_CLKS);
        line(1'b1, 64);
        check_val("x5a_ready_cnt", 32'(ready_total - r0), 32'd1);
        check_val("x5a_data",      32'(RxD_data), 32'h5A);

        // Baud mismatch: 31 and 33 clk per bit
        r0 = ready_total; e0 = err_total;
        send_frame(8'hC3, 1'b1, 31);
        line(1'b1, 64);
        check_val("fast_ready_cnt", 32'(ready_total - r0), 32'd1);
        check_val("fast_data",      32'(RxD_data), 32'hC3);
        check_val("fast_err_cnt",   32'(err_total - e0), 32'd0);
        r0 = ready_total; e0 = err_total;
        send_frame(8'hC3, 1'b1, 33);
        line(1'b1, 64);
        check_val("slow_ready_cnt", 32'(ready_total - r0), 32'd1);
        check_val("slow_data",      32'(RxD_data), 32'hC3);
        check_val("slow_err_cnt",   32'(err_total - e0), 32'd0);

        check_val("never_both", 32'(both_total), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_byte_receiver.md
UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, serial bit rate in bit/s.
REQ-003 Parameter OVERSAMPLE, default 16, oversample ticks per bit; fixed at 16 for this block.
REQ-004 Port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1; reset is synchronous and active-low.
REQ-006 Port RxD, input, 1, asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 Port RxD_data, output, 8, last correctly framed byte.
REQ-008 Port RxD_data_ready, output, 1, one-clk pulse when RxD_data is updated.
REQ-009 Port RxD_data_error, output, 1, one-clk pulse on framing error.

Function
REQ-010 RxD SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-011 The tick generator SHALL pulse once every DIV = round(CLK_FREQ/(BAUD*16)) clocks, minimum 1, and SHALL restart at 0 on start-edge detection.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE: a synchronized high-to-low transition SHALL move to START and clear the tick and sample counters.
REQ-014 START: on the 8th tick, the line SHALL be sampled; low goes to DATA, high (glitch) returns to IDLE with no output activity.
REQ-015 DATA: each bit SHALL be a majority vote of synchronized RxD on ticks 7, 8 and 9 of its 16-tick bit period, shifted in LSB first; after bit 7 the FSM goes to STOP.
REQ-016 STOP: the stop bit SHALL be majority-voted the same way; decision at tick 9.
REQ-017 Stop = 1: RxD_data SHALL load the assembled byte and RxD_data_ready SHALL pulse high for exactly one clk in the following cycle; the FSM returns to IDLE.
REQ-018 Stop = 0: RxD_data_error SHALL pulse for one clk, RxD_data SHALL hold its previous value, RxD_data_ready stays 0, and the FSM goes to WAIT_IDLE.
REQ-019 WAIT_IDLE: the FSM SHALL stay until synchronized RxD is high, then go to IDLE; a continuous low (break) SHALL produce only one error pulse.
REQ-020 Back-to-back frames: a start edge arriving anywhere after the stop decision SHALL be accepted, with no dead time beyond one clk.
REQ-021 RxD_data_ready and RxD_data_error SHALL never be high in the same cycle.
REQ-022 Latency: the ready pulse SHALL occur about 9.5 bit periods + 3 clk after the start falling edge at the pin.
REQ-023 The receiver SHALL tolerate at least +/-3% baud mismatch.

Reset
REQ-024 While rst_n is sampled low: FSM = IDLE, counters = 0, synchronizer = 1, RxD_data = 8'h00, RxD_data_ready = 0, RxD_data_error = 0.
REQ-025 Reset mid-frame SHALL discard the partial byte; reception restarts from the next start edge after release.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, OVERSAMPLE = 16, and the DIV computation function.
REQ-027 One sub-module, uart_rx_tick_gen (parameterized divider with sync clear, tick output), SHALL be used; FSM, synchronizer and shift register stay in uart_byte_receiver.

Verification
Bench parameters: CLK_FREQ = 3_200_000 and BAUD = 100_000, giving DIV = 2 and 32 clk per bit.
REQ-028 Frame 0xA5 at 32 clk/bit -> RxD_data = 0xA5, exactly one ready pulse, error = 0 throughout.
REQ-029 Frame 0x3C with stop bit 0, then line held low for 20 bit times -> exactly one error pulse, no ready pulse, RxD_data remains 0xA5; a following 0x81 frame after the line returns high is received correctly.
REQ-030 Low glitch of 6 clk on an idle line -> no ready pulse, no error pulse; a following 0x42 frame is received correctly.
REQ-031 Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three ready pulses with data 0x00, 0xFF, 0x55 in order.
REQ-032 rst_n low for 2 clk during data bit 3 of a frame -> outputs go to 0 and no ready pulse for that frame; a subsequent frame 0x5A yields 0x5A.
REQ-033 Frame 0xC3 sent at 31 and at 33 clk/bit -> both received as 0xC3 with no error pulse.
